// File: rtl/sig_preemphasis.sv
// Microphone front end: leaky-integrator DC removal followed by first-order
// pre-emphasis, delivered on a valid/rdy stream with a sticky saturation flag.
module sig_preemphasis #(
  parameter int DC_SHIFT = 10,
  parameter int PE_SHIFT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic [15:0] raw_data,
  input  logic        raw_valid,
  output logic        raw_rdy,
  output logic [15:0] audio_data,
  output logic        audio_valid,
  input  logic        audio_rdy,
  output logic        clip
);

  localparam int ACC_W = 18 + DC_SHIFT;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W:0]   acc_sum;
  logic signed [17:0]      dc;
  logic signed [15:0]      raw_s;
  logic signed [18:0]      diff;
  logic signed [15:0]      d;
  logic                    d_clamped;
  logic signed [15:0]      s1_data;
  logic                    s1_valid;
  logic signed [15:0]      prev;
  logic signed [15:0]      pe_tap;
  logic signed [17:0]      t;
  logic signed [15:0]      y;
  logic                    t_clamped;
  logic                    en;
  logic                    accept;

  assign en      = !audio_valid || audio_rdy;
  assign raw_rdy = en && !init;
  assign accept  = raw_valid && raw_rdy;

  // acc has DC_SHIFT fractional bits, so the shifted tracker always fits 18 bits
  assign raw_s  = raw_data;
  assign dc     = 18'(acc >>> DC_SHIFT);
  assign pe_tap = prev >>> PE_SHIFT;

  always_comb begin
    diff      = {{3{raw_s[15]}}, raw_s} - {dc[17], dc};
    d         = diff[15:0];
    d_clamped = 1'b0;
    if (diff > 19'sd32767) begin
      d         = 16'sh7fff;
      d_clamped = 1'b1;
    end else if (diff < -19'sd32768) begin
      d         = 16'sh8000;
      d_clamped = 1'b1;
    end
  end

  always_comb begin
    acc_sum  = {acc[ACC_W-1], acc} + {{(ACC_W-15){d[15]}}, d};
    acc_next = acc_sum[ACC_W-1:0];
    if (acc_sum[ACC_W] != acc_sum[ACC_W-1])
      acc_next = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
  end

  always_comb begin
    t = {{2{s1_data[15]}}, s1_data} - {{2{prev[15]}}, prev} + {{2{pe_tap[15]}}, pe_tap};
    y         = t[15:0];
    t_clamped = 1'b0;
    if (t > 18'sd32767) begin
      y         = 16'sh7fff;
      t_clamped = 1'b1;
    end else if (t < -18'sd32768) begin
      y         = 16'sh8000;
      t_clamped = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      prev        <= '0;
      s1_data     <= '0;
      s1_valid    <= 1'b0;
      audio_data  <= '0;
      audio_valid <= 1'b0;
      clip        <= 1'b0;
    end else if (init) begin
      acc         <= '0;
      prev        <= '0;
      s1_valid    <= 1'b0;
      audio_valid <= 1'b0;
      clip        <= 1'b0;
    end else if (en) begin
      if (accept) begin
        s1_data  <= d;
        s1_valid <= 1'b1;
        acc      <= acc_next;
      end else begin
        s1_valid <= 1'b0;
      end
      // bubbles leave prev and audio_data untouched so history tracks real samples only
      if (s1_valid) begin
        audio_data  <= y;
        prev        <= s1_data;
        audio_valid <= 1'b1;
      end else begin
        audio_valid <= 1'b0;
      end
      if ((accept && d_clamped) || (s1_valid && t_clamped))
        clip <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sig_preemphasis.sv
// Scoreboard bench for sig_preemphasis: table vectors for step/saturation,
// model-driven sequences for stalls, bubbles, init and async reset.
module tb_sig_preemphasis;
  localparam int DC_SHIFT = 10;
  localparam int PE_SHIFT = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        init;
  logic [15:0] raw_data;
  logic        raw_valid;
  logic        raw_rdy;
  logic [15:0] audio_data;
  logic        audio_valid;
  logic        audio_rdy;
  logic        clip;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sig_preemphasis #(.DC_SHIFT(DC_SHIFT), .PE_SHIFT(PE_SHIFT)) dut (
    .clk(clk), .rst(rst), .init(init),
    .raw_data(raw_data), .raw_valid(raw_valid), .raw_rdy(raw_rdy),
    .audio_data(audio_data), .audio_valid(audio_valid), .audio_rdy(audio_rdy),
    .clip(clip)
  );

  typedef struct {
    int val;
    bit chk_clip;
    bit clip;
  } exp_t;

  typedef struct {
    bit do_init;
    int raw;
    int exp_out;
    bit chk_clip;
    bit exp_clip;
  } vec_t;

  exp_t        sbq[$];
  longint      m_acc;
  int          m_prev;
  bit          m_clip;
  bit          last_acc;
  bit          prev_stall;
  logic [15:0] held;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic longint clamp16(longint v);
    if (v > 32767) begin m_clip = 1; return 32767; end
    if (v < -32768) begin m_clip = 1; return -32768; end
    return v;
  endfunction

  function automatic int model_step(int raw);
    longint dc, lim, t;
    int     d;
    lim   = longint'(1) <<< (17 + DC_SHIFT);
    dc    = m_acc >>> DC_SHIFT;
    d     = int'(clamp16(longint'(raw) - dc));
    m_acc = m_acc + d;
    if (m_acc > lim - 1) m_acc = lim - 1;
    if (m_acc < -lim)    m_acc = -lim;
    t      = longint'(d) - m_prev + (m_prev >>> PE_SHIFT);
    m_prev = d;
    return int'(clamp16(t));
  endfunction

  task automatic model_reset();
    m_acc = 0; m_prev = 0; m_clip = 0;
    sbq.delete();
    prev_stall = 0;
  endtask

  task automatic drive(input int raw, input bit v, input bit r, input bit in_init);
    raw_data  = 16'(raw);
    raw_valid = v;
    audio_rdy = r;
    init      = in_init;
  endtask

  // One clock: observe handshakes just before the edge, then move to the next negedge.
  task automatic cycle(input bit use_tab, input int tab_val, input bit tab_chk, input bit tab_clip);
    exp_t e;
    bit   was_init;
    #1;
    was_init = init;
    last_acc = raw_valid && raw_rdy;
    if (prev_stall && audio_valid) check("stall_hold", audio_data, held);
    if (audio_valid && !audio_rdy) begin
      check("stall_rdy", raw_rdy, 0);
      held = audio_data;
      prev_stall = 1;
    end else begin
      prev_stall = 0;
    end
    if (audio_valid && audio_rdy && !was_init) begin
      if (sbq.size() == 0) begin
        check("unexpected_out", $signed(audio_data), 32'sh7fffffff);
      end else begin
        e = sbq.pop_front();
        check("out_data", $signed(audio_data), e.val);
        if (e.chk_clip) check("out_clip", clip, e.clip);
      end
    end
    if (last_acc && !was_init) begin
      if (use_tab) begin
        e.val = tab_val; e.chk_clip = tab_chk; e.clip = tab_clip;
      end else begin
        e.val = model_step(int'($signed(raw_data)));
        e.chk_clip = 1; e.clip = m_clip;
      end
      sbq.push_back(e);
    end
    @(negedge clk);
    if (was_init) model_reset();
  endtask

  task automatic do_init();
    drive(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    check("init_valid", audio_valid, 0);
    check("init_clip", clip, 0);
    drive(0, 0, 1, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sbq.size() > 0; i++) begin
      drive(0, 0, 1, 0);
      cycle(0, 0, 0, 0);
    end
    check("drain_empty", sbq.size(), 0);
  endtask

  vec_t vecs[6];
  int   ramp[8];
  int   idx;
  int   cyc;

  initial begin
    vecs[0] = '{1, 1000, 1000, 1, 0};
    vecs[1] = '{0, 1000, 31, 1, 0};
    vecs[2] = '{0, 1000, 30, 1, 0};
    vecs[3] = '{0, 1000, 30, 1, 0};
    vecs[4] = '{1, -32768, -32768, 0, 0};
    vecs[5] = '{0, 32767, 32767, 1, 1};

    rst = 1; drive(0, 0, 0, 0);
    model_reset();
    #1;
    check("rst_valid", audio_valid, 0);
    check("rst_clip", clip, 0);
    check("rst_data", audio_data, 0);
    check("rst_raw_rdy", raw_rdy, 1);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].do_init) begin
        drain();
        do_init();
      end
      drive(vecs[i].raw, 1, 1, 0);
      cycle(1, vecs[i].exp_out, vecs[i].chk_clip, vecs[i].exp_clip);
      check("vec_accept", last_acc, 1);
    end
    drain();
    check("clip_sticky", clip, 1);

    // backpressure on a ramp, 5 stalled cycles mid-stream
    do_init();
    for (int i = 0; i < 8; i++) ramp[i] = i * 1500 - 4000;
    idx = 0; cyc = 0;
    while (idx < 8 && cyc < 40) begin
      drive(ramp[idx], 1, !(cyc >= 3 && cyc < 8), 0);
      cycle(0, 0, 0, 0);
      if (last_acc) idx++;
      cyc++;
    end
    check("bp_accepted", idx, 8);
    drain();

    // bubbles: model advances only on accepted samples
    do_init();
    idx = 0;
    for (int i = 0; i < 12; i++) begin
      drive(ramp[idx % 8] + 700, i % 2 == 0, 1, 0);
      cycle(0, 0, 0, 0);
      if (last_acc) idx++;
    end
    check("bubble_accepted", idx, 6);
    drain();

    // init with two samples in flight; they set clip first
    do_init();
    drive(-32768, 1, 0, 0); cycle(0, 0, 0, 0);
    drive(32767, 1, 0, 0);  cycle(0, 0, 0, 0);
    drive(0, 0, 0, 0);      cycle(0, 0, 0, 0);
    check("pre_init_clip", clip, 1);
    do_init();
    drive(12345, 1, 1, 0);
    cycle(1, 12345, 1, 0);
    drain();

    // async reset while stalled
    drive(-32768, 1, 1, 0); cycle(0, 0, 0, 0);
    drive(32767, 1, 1, 0);  cycle(0, 0, 0, 0);
    drive(0, 0, 0, 0);      cycle(0, 0, 0, 0);
    check("pre_rst_valid", audio_valid, 1);
    #2 rst = 1;
    #1;
    check("async_valid", audio_valid, 0);
    check("async_clip", clip, 0);
    check("async_data", audio_data, 0);
    @(negedge clk);
    rst = 0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      drive(ramp[i] + 333, 1, 1, 0);
      cycle(0, 0, 0, 0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
